mm_seq_ctrl: RTL

- Top-level sequencer for the matrix-multiply datapath.
- Accepts a start command and loads one input matrix into the input buffer through a valid/ready stream.
- Runs the multiply-accumulate ALU until it reports completion.
- Captures each group of four MU results on the ALU write strobe and serialises them into the result RAM, one word per cycle.

---
 rtl/mm_seq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mm_seq_ctrl.sv
// Matrix-multiply sequencer: loads one input frame, runs the MAC ALU, and
// serialises each captured group of four MU results into the result RAM.
module mm_seq_ctrl #(
  parameter int unsigned IN_WORDS = 8,
  parameter int unsigned IN_AW    = 3,
  parameter int unsigned RES_W    = 18,
  parameter int unsigned RES_AW   = 4,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_buf_we,
  output logic [IN_AW-1:0]  o_buf_addr,
  output logic              o_alu_en,
  input  logic              i_alu_web,
  input  logic              i_alu_done,
  input  logic [RES_W-1:0]  i_mu1,
  input  logic [RES_W-1:0]  i_mu2,
  input  logic [RES_W-1:0]  i_mu3,
  input  logic [RES_W-1:0]  i_mu4,
  output logic              o_ram_we,
  output logic [RES_AW-1:0] o_ram_addr,
  output logic [RES_W-1:0]  o_ram_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned LW = $clog2(IN_WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic [IN_AW-1:0]  r_buf_addr;
  logic [LW-1:0]     r_ld_cnt;
  logic              r_alu_en;
  logic [CW-1:0]     r_cyc;
  logic [RES_W-1:0]  r_buf [4];
  logic [2:0]        r_wr_cnt;
  logic [1:0]        r_idx;
  logic              r_ram_we;
  logic [RES_AW-1:0] r_ram_addr;
  logic [RES_W-1:0]  r_ram_wdata;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_err;

  logic              w_accept;
  logic              w_last_accept;
  logic              w_cap;
  logic              w_timeout;
  logic [1:0]        w_nxt_idx;

  assign w_accept      = i_in_valid & r_in_ready;
  assign w_last_accept = w_accept && (r_ld_cnt == LW'(IN_WORDS - 1));
  assign w_cap         = i_alu_web && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_timeout     = (r_cyc == CW'(TIMEOUT - 1));
  assign w_nxt_idx     = r_idx + 2'd1;

  // The buffer write strobe tracks the handshake in the same cycle.
  assign o_buf_we    = w_accept;
  assign o_in_ready  = r_in_ready;
  assign o_buf_addr  = r_buf_addr;
  assign o_alu_en    = r_alu_en;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_buf_addr  <= '0;
      r_ld_cnt    <= '0;
      r_alu_en    <= 1'b0;
      r_cyc       <= '0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
      r_wr_cnt    <= '0;
      r_idx       <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= '0;
    end else begin
      r_done <= 1'b0;

      // Serialiser: a new capture always wins over the group in flight.
      if (r_ram_we) r_ram_addr <= r_ram_addr + RES_AW'(1);
      if (w_cap) begin
        r_buf[0]    <= i_mu1;
        r_buf[1]    <= i_mu2;
        r_buf[2]    <= i_mu3;
        r_buf[3]    <= i_mu4;
        r_wr_cnt    <= 3'd4;
        r_idx       <= 2'd0;
        r_ram_we    <= 1'b1;
        r_ram_wdata <= i_mu1;
        if (r_wr_cnt != 3'd0) r_err[0] <= 1'b1;
      end else if (r_ram_we) begin
        r_wr_cnt <= r_wr_cnt - 3'd1;
        if (r_wr_cnt > 3'd1) begin
          r_idx       <= w_nxt_idx;
          r_ram_wdata <= r_buf[w_nxt_idx];
        end else begin
          r_ram_we <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_err      <= '0;
            r_ld_cnt   <= '0;
            r_buf_addr <= '0;
            r_ram_addr <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_ld_cnt   <= r_ld_cnt + LW'(1);
            r_buf_addr <= r_buf_addr + IN_AW'(1);
          end
          if (w_last_accept) begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_alu_en   <= 1'b1;
            r_cyc      <= '0;
          end
        end
        S_RUN: begin
          r_cyc <= r_cyc + CW'(1);
          if (i_alu_done || w_timeout) begin
            r_state  <= S_DRAIN;
            r_alu_en <= 1'b0;
            if (!i_alu_done) r_err[1] <= 1'b1;
          end
        end
        S_DRAIN: begin
          if ((r_wr_cnt == 3'd0) && !r_ram_we && !w_cap) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
